// File: rtl/imem_uart_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_loader_pkg                                                  |
// | Shared types and UART framing constants for the image loader.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        WORD   = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_uart_loader_uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx                                                          |
// | 8N1 receiver: synchroniser, mid-bit sampling, 1-cycle strobes.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 i_rx,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_ferr
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       c_LAST_BIT = 3'(DATA_BITS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic                 w_rx;
    logic [1:0]           r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;

    assign w_rx   = r_sync[1];
    assign o_data = r_shift;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_prev  <= w_rx;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        o_valid     = 1'b0;
        o_ferr      = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (r_prev && !w_rx) w_state_nxt = c_START;
            end
            c_START: begin
                // A line that is high again at mid start bit was only a glitch
                if (r_cnt == c_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (r_cnt == c_FULL) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == c_LAST_BIT) w_state_nxt = c_STOP;
                end
            end
            c_STOP: begin
                if (r_cnt == c_FULL) begin
                    w_state_nxt = c_IDLE;
                    o_valid     = w_rx;
                    o_ferr      = !w_rx;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_uart_loader                                                 |
// | Instruction memory filled from a UART image; holds core in reset.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              uart_rx,
    input  logic              reload,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              core_rst_n,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int              CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int              DEPTH        = 2 ** ADDR_W;
    localparam int              TO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] c_TIMEOUT    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [16:0]     c_DEPTH      = 17'(DEPTH);

    logic                 w_rx_valid;
    logic                 w_rx_ferr;
    logic [DATA_BITS-1:0] w_rx_data;

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_count_hi;
    logic [15:0]          r_count;
    logic [15:0]          w_count;
    logic [23:0]          r_word;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [1:0]           r_byte_idx;
    logic [ADDR_W:0]      r_words_loaded;
    logic [TO_W-1:0]      r_idle;
    logic                 r_core_rst_n;
    logic                 w_timeout;
    logic                 w_all_in;
    logic                 w_start_load;
    logic                 w_take_byte;
    logic                 w_reload;
    logic                 w_mem_we;
    logic                 w_unused_pc;

    logic [31:0]          r_mem [DEPTH];

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_rx    (uart_rx),
        .o_valid (w_rx_valid),
        .o_data  (w_rx_data),
        .o_ferr  (w_rx_ferr)
    );

    assign w_count   = {r_count_hi, w_rx_data};
    assign w_timeout = (r_idle == c_TIMEOUT);
    assign w_all_in  = (16'(r_words_loaded) == r_count);
    assign w_mem_we  = w_take_byte && (r_byte_idx == 2'd3);

    always_comb begin
        w_state_nxt  = r_state;
        w_start_load = 1'b0;
        w_take_byte  = 1'b0;
        w_reload     = 1'b0;
        case (r_state)
            LEN_HI: begin
                if (w_rx_valid) w_state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (w_rx_valid) begin
                    if (w_count == 16'd0) begin
                        w_state_nxt = DONE;
                    end else if ({1'b0, w_count} > c_DEPTH) begin
                        w_state_nxt = ERROR;
                    end else begin
                        w_state_nxt  = WORD;
                        w_start_load = 1'b1;
                    end
                end else if (w_rx_ferr || w_timeout) begin
                    w_state_nxt = ERROR;
                end
            end
            WORD: begin
                // Completion is seen the cycle after the last word is written
                if (w_all_in) begin
                    w_state_nxt = DONE;
                end else if (w_rx_valid) begin
                    w_take_byte = 1'b1;
                end else if (w_rx_ferr || w_timeout) begin
                    w_state_nxt = ERROR;
                end
            end
            DONE, ERROR: begin
                if (reload) begin
                    w_state_nxt = LEN_HI;
                    w_reload    = 1'b1;
                end
            end
            default: w_state_nxt = LEN_HI;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state        <= LEN_HI;
            r_count_hi     <= '0;
            r_count        <= '0;
            r_word         <= '0;
            r_wr_addr      <= '0;
            r_byte_idx     <= '0;
            r_words_loaded <= '0;
            r_idle         <= '0;
            r_core_rst_n   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_rst_n <= (r_state == DONE) && (w_state_nxt == DONE);

            if (r_state == LEN_HI && w_rx_valid) r_count_hi <= w_rx_data;
            if (r_state == LEN_LO && w_rx_valid) r_count    <= w_count;

            if (w_start_load || w_reload) begin
                r_wr_addr      <= '0;
                r_byte_idx     <= '0;
                r_words_loaded <= '0;
            end else if (w_take_byte) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_word[7:0]   <= w_rx_data;
                    2'd1:    r_word[15:8]  <= w_rx_data;
                    2'd2:    r_word[23:16] <= w_rx_data;
                    default: begin
                        r_wr_addr      <= r_wr_addr + 1'b1;
                        r_words_loaded <= r_words_loaded + 1'b1;
                    end
                endcase
            end

            if ((r_state == LEN_LO || r_state == WORD) && !w_rx_valid) begin
                if (!w_timeout) r_idle <= r_idle + 1'b1;
            end else begin
                r_idle <= '0;
            end
        end
    end

    // The fourth byte goes straight from the receiver into the array
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_wr_addr] <= {w_rx_data, r_word};
    end

    assign instr        = r_mem[pc[ADDR_W+1:2]];
    assign w_unused_pc  = ^{pc[31:ADDR_W+2], pc[1:0]};

    assign core_rst_n   = r_core_rst_n;
    assign load_busy    = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == WORD);
    assign load_done    = (r_state == DONE);
    assign load_err     = (r_state == ERROR);
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire
